// File: rtl/sim_program_ctrl.sv
// Simulation program controller.
// Streams a program into main memory, pulses the core's init, lets the core run until its
// PC hits END_PC (or a cycle budget runs out), then dumps a snapshot of the architectural
// register file one entry per handshake.
//
// Ports:
//   clk, rst_aH                     clock, asynchronous active-high reset
//   start, init_pc                  run request (level) and first instruction address
//   instr_valid/ready/data          program word stream
//   mem_wr_valid/ready/block_addr/
//     block_offset/data             main-memory write port
//   core_init, core_init_pc         one-cycle init pulse and start PC for the core
//   core_pc                         core fetch PC, watched for END_PC
//   arf_state                       flattened register file, entry i at [i*W +: W]
//   dump_valid/ready/idx/data       register dump stream
//   run_cycles, done, timed_out     run status
module sim_program_ctrl #(
  parameter int unsigned N_WORDS            = 16,
  parameter int unsigned BLOCK_OFFSET_WIDTH = 3,
  parameter logic [31:0] END_PC             = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES     = 4096,
  parameter int unsigned ARF_N_ENTRIES      = 32,
  parameter int unsigned REG_DATA_WIDTH     = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_aH,
  input  logic                                    start,
  input  logic [31:0]                             init_pc,
  input  logic                                    instr_valid,
  output logic                                    instr_ready,
  input  logic [31:0]                             instr_data,
  output logic                                    mem_wr_valid,
  input  logic                                    mem_wr_ready,
  output logic [31-BLOCK_OFFSET_WIDTH:0]          mem_wr_block_addr,
  output logic [BLOCK_OFFSET_WIDTH-1:0]           mem_wr_block_offset,
  output logic [31:0]                             mem_wr_data,
  output logic                                    core_init,
  output logic [31:0]                             core_init_pc,
  input  logic [31:0]                             core_pc,
  input  logic [ARF_N_ENTRIES*REG_DATA_WIDTH-1:0] arf_state,
  output logic                                    dump_valid,
  input  logic                                    dump_ready,
  output logic [$clog2(ARF_N_ENTRIES)-1:0]        dump_idx,
  output logic [REG_DATA_WIDTH-1:0]               dump_data,
  output logic [31:0]                             run_cycles,
  output logic                                    done,
  output logic                                    timed_out
);

  localparam int unsigned WcntW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int unsigned IdxW  = $clog2(ARF_N_ENTRIES);

  localparam logic [WcntW-1:0] LastWord    = WcntW'(N_WORDS - 1);
  localparam logic [IdxW-1:0]  LastIdx     = IdxW'(ARF_N_ENTRIES - 1);
  localparam logic [31:0]      TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StInit = 3'd2;
  localparam logic [2:0] StRun  = 3'd3;
  localparam logic [2:0] StDump = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [WcntW-1:0] wcnt_q, wcnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      init_pc_q, init_pc_d;
  logic [31:0]      run_cycles_q, run_cycles_d;
  logic             timed_out_q, timed_out_d;
  logic [IdxW-1:0]  dump_idx_q, dump_idx_d;
  logic             snap_en;

  logic [REG_DATA_WIDTH-1:0] arf_unpacked [ARF_N_ENTRIES];
  logic [REG_DATA_WIDTH-1:0] snap_q       [ARF_N_ENTRIES];

  for (genvar g = 0; g < ARF_N_ENTRIES; g++) begin : g_arf_unpack
    assign arf_unpacked[g] = arf_state[g*REG_DATA_WIDTH +: REG_DATA_WIDTH];
  end

  logic in_load, wr_fire, dump_fire;

  // The handshake is a pass-through between stream and memory while loading; everything
  // memory-facing is forced to zero outside LOAD so idle/reset outputs are clean.
  always_comb begin
    in_load             = (state_q == StLoad);
    mem_wr_valid        = in_load & instr_valid;
    instr_ready         = in_load & mem_wr_ready;
    wr_fire             = in_load & instr_valid & mem_wr_ready;
    mem_wr_block_addr   = in_load ? addr_q[31:BLOCK_OFFSET_WIDTH] : '0;
    mem_wr_block_offset = in_load ? addr_q[BLOCK_OFFSET_WIDTH-1:0] : '0;
    mem_wr_data         = in_load ? instr_data : '0;
    core_init           = (state_q == StInit);
    core_init_pc        = init_pc_q;
    dump_valid          = (state_q == StDump);
    dump_fire           = dump_valid & dump_ready;
    dump_idx            = dump_idx_q;
    dump_data           = dump_valid ? snap_q[dump_idx_q] : '0;
    run_cycles          = run_cycles_q;
    done                = (state_q == StDone);
    timed_out           = timed_out_q;
  end

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    addr_d       = addr_q;
    init_pc_d    = init_pc_q;
    run_cycles_d = run_cycles_q;
    timed_out_d  = timed_out_q;
    dump_idx_d   = dump_idx_q;
    snap_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StLoad;
          init_pc_d    = init_pc;
          addr_d       = init_pc;
          wcnt_d       = '0;
          run_cycles_d = '0;
          timed_out_d  = 1'b0;
          dump_idx_d   = '0;
        end
      end
      StLoad: begin
        if (wr_fire) begin
          addr_d = addr_q + 32'd4;
          if (wcnt_q == LastWord) begin
            state_d = StInit;
          end else begin
            wcnt_d = wcnt_q + WcntW'(1);
          end
        end
      end
      StInit: state_d = StRun;
      StRun: begin
        run_cycles_d = (run_cycles_q == '1) ? run_cycles_q : run_cycles_q + 32'd1;
        // PC match takes priority over the timeout in the same cycle.
        if (core_pc == END_PC) begin
          state_d    = StDump;
          snap_en    = 1'b1;
          dump_idx_d = '0;
        end else if (run_cycles_q == TimeoutLast) begin
          state_d     = StDone;
          timed_out_d = 1'b1;
        end
      end
      StDump: begin
        if (dump_fire) begin
          if (dump_idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            dump_idx_d = dump_idx_q + IdxW'(1);
          end
        end
      end
      StDone: begin
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      state_q      <= StIdle;
      wcnt_q       <= '0;
      addr_q       <= '0;
      init_pc_q    <= '0;
      run_cycles_q <= '0;
      timed_out_q  <= 1'b0;
      dump_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      addr_q       <= addr_d;
      init_pc_q    <= init_pc_d;
      run_cycles_q <= run_cycles_d;
      timed_out_q  <= timed_out_d;
      dump_idx_q   <= dump_idx_d;
    end
  end

  // Snapshot is pure datapath; dump_data is gated by dump_valid so it needs no reset.
  always_ff @(posedge clk) begin
    if (snap_en) snap_q <= arf_unpacked;
  end

endmodule

// File: tb/tb_sim_program_ctrl.sv
module tb_sim_program_ctrl;

  localparam int NW      = 15;
  localparam int TIMEOUT = 100;
  localparam int NREG    = 32;

  logic          clk = 1'b0;
  logic          rst_aH;
  logic          start;
  logic [31:0]   init_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr_data;
  logic          mem_wr_valid;
  logic          mem_wr_ready;
  logic [28:0]   mem_wr_block_addr;
  logic [2:0]    mem_wr_block_offset;
  logic [31:0]   mem_wr_data;
  logic          core_init;
  logic [31:0]   core_init_pc;
  logic [31:0]   core_pc;
  logic [1023:0] arf_state;
  logic          dump_valid;
  logic          dump_ready;
  logic [4:0]    dump_idx;
  logic [31:0]   dump_data;
  logic [31:0]   run_cycles;
  logic          done;
  logic          timed_out;

  sim_program_ctrl #(
    .N_WORDS           (NW),
    .BLOCK_OFFSET_WIDTH(3),
    .END_PC            (32'h0),
    .TIMEOUT_CYCLES    (TIMEOUT),
    .ARF_N_ENTRIES     (NREG),
    .REG_DATA_WIDTH    (32)
  ) dut (
    .clk                (clk),
    .rst_aH             (rst_aH),
    .start              (start),
    .init_pc            (init_pc),
    .instr_valid        (instr_valid),
    .instr_ready        (instr_ready),
    .instr_data         (instr_data),
    .mem_wr_valid       (mem_wr_valid),
    .mem_wr_ready       (mem_wr_ready),
    .mem_wr_block_addr  (mem_wr_block_addr),
    .mem_wr_block_offset(mem_wr_block_offset),
    .mem_wr_data        (mem_wr_data),
    .core_init          (core_init),
    .core_init_pc       (core_init_pc),
    .core_pc            (core_pc),
    .arf_state          (arf_state),
    .dump_valid         (dump_valid),
    .dump_ready         (dump_ready),
    .dump_idx           (dump_idx),
    .dump_data          (dump_data),
    .run_cycles         (run_cycles),
    .done               (done),
    .timed_out          (timed_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // end_cycle: RUN cycle (1-based) in which core_pc reads END_PC, 0 = never.
  // mode: 0 = always ready, 1 = every 3rd cycle invalid + toggling ready, 2 = random.
  // abort_beat: dump beat at which reset is pulsed, -1 = none.
  typedef struct {
    logic [31:0] pc;
    int          end_cycle;
    int          mode;
    int          abort_beat;
    logic        exp_to;
    logic [31:0] exp_rc;
    logic        exp_dump;
  } vec_t;

  vec_t vecs[6];

  logic [31:0] snap [NREG];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] pc, input int k);
    return pc ^ (32'(k) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  task automatic randomize_arf();
    for (int i = 0; i < NREG; i++) arf_state[i*32 +: 32] = $urandom;
    arf_state[32 +: 32] = 32'h07213241;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".instr_ready"}, 32'(instr_ready), 0);
    check({tag, ".mem_wr_valid"}, 32'(mem_wr_valid), 0);
    check({tag, ".mem_wr_addr"}, {mem_wr_block_addr, mem_wr_block_offset}, 0);
    check({tag, ".mem_wr_data"}, mem_wr_data, 0);
    check({tag, ".core_init"}, 32'(core_init), 0);
    check({tag, ".core_init_pc"}, core_init_pc, 0);
    check({tag, ".dump_valid"}, 32'(dump_valid), 0);
    check({tag, ".dump_idx"}, 32'(dump_idx), 0);
    check({tag, ".dump_data"}, dump_data, 0);
    check({tag, ".run_cycles"}, run_cycles, 0);
    check({tag, ".done"}, 32'(done), 0);
    check({tag, ".timed_out"}, 32'(timed_out), 0);
  endtask

  task automatic run_program(input vec_t v);
    int k;
    int cyc;
    int r;
    int beat;
    logic [31:0] exp_addr;

    // Idle: handshake inputs high must not leak through before start is accepted.
    start       = 1'b1;
    init_pc     = v.pc;
    instr_valid = 1'b1;
    mem_wr_ready = 1'b1;
    core_pc     = 32'hDEAD0000;
    #1;
    check("idle.mem_wr_valid", 32'(mem_wr_valid), 0);
    check("idle.instr_ready", 32'(instr_ready), 0);
    check("idle.core_init", 32'(core_init), 0);
    cycle();

    // Load: scoreboard of word k -> init_pc + 4k.
    k   = 0;
    cyc = 0;
    while (k < NW && cyc < 2000) begin
      case (v.mode)
        0: begin instr_valid = 1'b1; mem_wr_ready = 1'b1; end
        1: begin instr_valid = (cyc % 3) != 2; mem_wr_ready = (cyc % 2) == 0; end
        default: begin instr_valid = 1'($urandom); mem_wr_ready = 1'($urandom); end
      endcase
      instr_data = word_of(v.pc, k);
      #1;
      check("load.valid_pass", 32'(mem_wr_valid), 32'(instr_valid));
      check("load.ready_pass", 32'(instr_ready), 32'(mem_wr_ready));
      check("load.core_init", 32'(core_init), 0);
      if (instr_valid && mem_wr_ready) begin
        exp_addr = v.pc + 32'(4 * k);
        check("load.addr", {mem_wr_block_addr, mem_wr_block_offset}, exp_addr);
        check("load.data", mem_wr_data, word_of(v.pc, k));
        k++;
      end
      cycle();
      cyc++;
    end
    if (k < NW) check("load.timeout", 32'(k), 32'(NW));
    if (v.mode == 0) check("init.latency", 32'(cyc), 32'(NW));

    // Init: exactly one pulse, no further writes.
    instr_valid  = 1'b1;
    mem_wr_ready = 1'b1;
    #1;
    check("init.core_init", 32'(core_init), 1);
    check("init.core_init_pc", core_init_pc, v.pc);
    check("init.no_extra_write", 32'(mem_wr_valid), 0);
    cycle();
    instr_valid = 1'b0;

    // Run: core_pc hits END_PC only in cycle end_cycle; budget is TIMEOUT cycles.
    r = 0;
    forever begin
      r++;
      core_pc = (r == v.end_cycle) ? 32'h0 : 32'h1000 + 32'(r);
      randomize_arf();
      #1;
      check("run.core_init", 32'(core_init), 0);
      check("run.dump_valid", 32'(dump_valid), 0);
      check("run.done", 32'(done), 0);
      check("run.cycles", run_cycles, 32'(r - 1));
      if (r == v.end_cycle) begin
        for (int i = 0; i < NREG; i++) snap[i] = arf_state[i*32 +: 32];
      end
      cycle();
      if (r == v.end_cycle || r == TIMEOUT) break;
    end
    core_pc = 32'h2000;
    randomize_arf();
    #1;
    check("end.run_cycles", run_cycles, v.exp_rc);
    check("end.timed_out", 32'(timed_out), 32'(v.exp_to));
    check("end.dump_valid", 32'(dump_valid), 32'(v.exp_dump));

    if (v.exp_dump) begin
      beat = 0;
      cyc  = 0;
      while (beat < NREG && cyc < 1000) begin
        if (beat == v.abort_beat) begin
          rst_aH = 1'b1;
          #1;
          check_all_zero("rst_dump");
          cycle();
          rst_aH = 1'b0;
          start  = 1'b0;
          return;
        end
        dump_ready = (v.mode == 0) ? 1'b1 : 1'($urandom);
        randomize_arf();
        #1;
        check("dump.valid", 32'(dump_valid), 1);
        check("dump.idx", 32'(dump_idx), 32'(beat));
        check("dump.data", dump_data, snap[beat]);
        if (dump_ready) beat++;
        cycle();
        cyc++;
      end
      if (beat < NREG) check("dump.timeout", 32'(beat), 32'(NREG));
      dump_ready = 1'b0;
    end

    // Done holds status while start stays high, returns to idle when start drops.
    #1;
    check("done.done", 32'(done), 1);
    check("done.dump_valid", 32'(dump_valid), 0);
    cycle();
    #1;
    check("done.hold", 32'(done), 1);
    check("done.run_cycles", run_cycles, v.exp_rc);
    check("done.timed_out", 32'(timed_out), 32'(v.exp_to));
    start = 1'b0;
    #1;
    check("done.before_drop", 32'(done), 1);
    cycle();
    #1;
    check("idle.done_cleared", 32'(done), 0);
  endtask

  initial begin
    vecs[0] = '{pc: 32'h0001018c, end_cycle: 40,  mode: 0, abort_beat: -1,
                exp_to: 1'b0, exp_rc: 32'd40,  exp_dump: 1'b1};
    vecs[1] = '{pc: 32'h00002000, end_cycle: 0,   mode: 1, abort_beat: -1,
                exp_to: 1'b1, exp_rc: 32'd100, exp_dump: 1'b0};
    vecs[2] = '{pc: 32'h00000040, end_cycle: 100, mode: 2, abort_beat: -1,
                exp_to: 1'b0, exp_rc: 32'd100, exp_dump: 1'b1};
    vecs[3] = '{pc: 32'hFFFFFFE8, end_cycle: 1,   mode: 2, abort_beat: -1,
                exp_to: 1'b0, exp_rc: 32'd1,   exp_dump: 1'b1};
    vecs[4] = '{pc: 32'h00400000, end_cycle: 5,   mode: 0, abort_beat: 10,
                exp_to: 1'b0, exp_rc: 32'd5,   exp_dump: 1'b1};
    vecs[5] = '{pc: 32'h00000100, end_cycle: 99,  mode: 2, abort_beat: -1,
                exp_to: 1'b0, exp_rc: 32'd99,  exp_dump: 1'b1};

    rst_aH       = 1'b1;
    start        = 1'b1;
    init_pc      = 32'hFFFF_FFFF;
    instr_valid  = 1'b1;
    instr_data   = 32'hFFFF_FFFF;
    mem_wr_ready = 1'b1;
    dump_ready   = 1'b1;
    core_pc      = 32'h0;
    arf_state    = '1;
    @(negedge clk);
    #1;
    check_all_zero("reset");
    cycle();
    rst_aH = 1'b0;
    start  = 1'b0;
    #1;
    check("post_reset.mem_wr_valid", 32'(mem_wr_valid), 0);
    check("post_reset.core_init", 32'(core_init), 0);
    cycle();

    // First write of the reference program lands in block 0x2031 at offset 4.
    check("split.block", 32'(vecs[0].pc[31:3]), 32'h2031);
    check("split.offset", 32'(vecs[0].pc[2:0]), 32'h4);

    for (int i = 0; i < 6; i++) run_program(vecs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
